// File: rtl/frac_lif_pkg.sv
// Shared types and fixed-point helpers for the fractional-order LIF neuron array.
// Q-format widths and the saturating clamp used by every arithmetic path.
package frac_lif_pkg;

  localparam int Q_W   = 32;
  localparam int Q_F   = 16;
  localparam int SAT_W = 2 * Q_W + 2;

  localparam logic signed [SAT_W-1:0] SAT_MAX = {{(SAT_W-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SAT_MIN = {{(SAT_W-Q_W+1){1'b1}}, {(Q_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_COMMIT,
    S_EMIT
  } state_t;

  // Clamp a wide intermediate into the signed Q_W range instead of wrapping.
  function automatic logic signed [Q_W-1:0] sat(input logic signed [SAT_W-1:0] x);
    logic signed [SAT_W-1:0] y;
    if (x > SAT_MAX) y = SAT_MAX;
    else if (x < SAT_MIN) y = SAT_MIN;
    else y = x;
    return y[Q_W-1:0];
  endfunction

endpackage

// File: rtl/frac_lif_stage_alu.sv
// One ladder stage update, purely combinational; the array time-shares a single copy.
// Produces this stage's capacitor/resistor current contributions and the new ladder voltage.
module frac_lif_stage_alu
  import frac_lif_pkg::*;
#(
  parameter int        W       = 32,
  parameter int        F       = 16,
  parameter int        R_SHIFT = 4,
  parameter int signed A_LAD   = 16384,
  parameter int signed B_LAD   = -16384
) (
  input  logic signed [W-1:0] i_prev,
  input  logic signed [W-1:0] i_vlad,
  output logic signed [W-1:0] o_dIcap,
  output logic signed [W-1:0] o_dIr,
  output logic signed [W-1:0] o_vladNext
);

  localparam int XW = SAT_W;

  logic signed [XW-1:0] w_p;
  logic signed [XW-1:0] w_v;
  logic signed [XW-1:0] w_d;
  logic signed [XW-1:0] w_lin;

  assign w_p   = XW'(i_prev);
  assign w_v   = XW'(i_vlad);
  assign w_d   = w_p - w_v;
  // The shared multiplier pair: coupling to the previous node plus the self term.
  assign w_lin = (XW'(A_LAD) * w_d) + (XW'(B_LAD) * w_v);

  assign o_dIcap    = sat(w_d >>> R_SHIFT);
  assign o_dIr      = sat(w_v >>> R_SHIFT);
  assign o_vladNext = sat(w_v + (w_lin >>> F));

endmodule

// File: rtl/frac_lif_array.sv
// Array of leaky integrate-and-fire neurons with an RC-ladder fractional-order memory.
// One update request at a time: accumulate ladder stages, commit, then hand out the result.
module frac_lif_array
  import frac_lif_pkg::*;
#(
  parameter int        N_NEUR  = 8,
  parameter int        N_STAGE = 3,
  parameter int        W       = 32,
  parameter int        F       = 16,
  parameter int        R_SHIFT = 4,
  parameter int signed K_TAU   = 6554,
  parameter int signed K_LEAK  = -6554,
  parameter int signed A_LAD   = 16384,
  parameter int signed B_LAD   = -16384,
  parameter int signed V_TH    = 32768,
  parameter int signed V_RESET = 32768,
  parameter int        T_REF   = 2,
  localparam int       ID_W    = (N_NEUR > 1) ? $clog2(N_NEUR) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ID_W-1:0]     in_id,
  input  logic signed [W-1:0] in_cur,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_W-1:0]     out_id,
  output logic signed [W-1:0] out_vmem,
  output logic                out_spike
);

  localparam int XW    = SAT_W;
  localparam int STG_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
  localparam int RW    = (T_REF > 0) ? $clog2(T_REF + 1) : 1;

  state_t r_state;
  state_t w_nextState;

  logic signed [W-1:0] r_vmem   [N_NEUR];
  logic signed [W-1:0] r_vlad   [N_NEUR][N_STAGE];
  logic [RW-1:0]       r_refrac [N_NEUR];
  logic signed [W-1:0] r_vladNew[N_STAGE];

  logic [ID_W-1:0]     r_id;
  logic signed [W-1:0] r_cur;
  logic signed [W-1:0] r_icap;
  logic signed [W-1:0] r_ir;
  logic [STG_W-1:0]    r_stage;
  logic [ID_W-1:0]     r_outId;
  logic signed [W-1:0] r_outVmem;
  logic                r_outSpike;

  logic                w_idOk;
  logic [ID_W-1:0]     w_safeId;
  logic signed [W-1:0] w_vmemCur;
  logic [RW-1:0]       w_refCur;
  logic [STG_W-1:0]    w_prevIdx;
  logic signed [W-1:0] w_prev;
  logic signed [W-1:0] w_vladCur;
  logic signed [W-1:0] w_dIcap;
  logic signed [W-1:0] w_dIr;
  logic signed [W-1:0] w_vladNext;
  logic signed [W-1:0] w_iinEff;
  logic signed [XW-1:0] w_leak;
  logic signed [W-1:0] w_s;
  logic signed [W-1:0] w_vnew;
  logic                w_spike;
  logic signed [W-1:0] w_vstore;

  // Out-of-range ids still run the pipeline, but read neuron 0 harmlessly and never write.
  assign w_idOk    = (int'(r_id) < N_NEUR);
  assign w_safeId  = w_idOk ? r_id : '0;
  assign w_vmemCur = r_vmem[w_safeId];
  assign w_refCur  = r_refrac[w_safeId];
  assign w_prevIdx = (r_stage == '0) ? '0 : r_stage - STG_W'(1);
  assign w_prev    = (r_stage == '0) ? w_vmemCur : r_vlad[w_safeId][w_prevIdx];
  assign w_vladCur = r_vlad[w_safeId][r_stage];

  frac_lif_stage_alu #(
    .W       (W),
    .F       (F),
    .R_SHIFT (R_SHIFT),
    .A_LAD   (A_LAD),
    .B_LAD   (B_LAD)
  ) u_stageAlu (
    .i_prev     (w_prev),
    .i_vlad     (w_vladCur),
    .o_dIcap    (w_dIcap),
    .o_dIr      (w_dIr),
    .o_vladNext (w_vladNext)
  );

  assign w_iinEff = (w_refCur != '0) ? '0 : r_cur;
  assign w_leak   = (XW'(K_LEAK) * XW'(w_vmemCur)) >>> F;
  assign w_s      = sat(XW'(w_iinEff) + w_leak - XW'(r_icap) + XW'(r_ir));
  assign w_vnew   = sat(XW'(w_vmemCur) + ((XW'(K_TAU) * XW'(w_s)) >>> F));
  assign w_spike  = (w_refCur == '0) && (w_vnew >= $signed(W'(V_TH)));
  assign w_vstore = w_spike ? sat(XW'(w_vnew) - XW'(V_RESET)) : w_vnew;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign out_id    = r_outId;
  assign out_vmem  = r_outVmem;
  assign out_spike = r_outSpike;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_nextState = S_ACC;
      S_ACC:    if (r_stage == STG_W'(N_STAGE - 1)) w_nextState = S_COMMIT;
      S_COMMIT: w_nextState = S_EMIT;
      S_EMIT:   if (out_ready) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Ladder results are staged in r_vladNew so every stage sees pre-update neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEUR; n++) begin
        r_vmem[n]   <= '0;
        r_refrac[n] <= '0;
        for (int j = 0; j < N_STAGE; j++) r_vlad[n][j] <= '0;
      end
      for (int j = 0; j < N_STAGE; j++) r_vladNew[j] <= '0;
      r_id       <= '0;
      r_cur      <= '0;
      r_icap     <= '0;
      r_ir       <= '0;
      r_stage    <= '0;
      r_outId    <= '0;
      r_outVmem  <= '0;
      r_outSpike <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_id    <= in_id;
            r_cur   <= in_cur;
            r_icap  <= '0;
            r_ir    <= '0;
            r_stage <= '0;
          end
        end
        S_ACC: begin
          r_vladNew[r_stage] <= w_vladNext;
          r_icap  <= sat(XW'(r_icap) + XW'(w_dIcap));
          r_ir    <= sat(XW'(r_ir) + XW'(w_dIr));
          r_stage <= r_stage + STG_W'(1);
        end
        S_COMMIT: begin
          r_outId    <= r_id;
          r_outVmem  <= w_idOk ? w_vstore : '0;
          r_outSpike <= w_idOk && w_spike;
          if (w_idOk) begin
            r_vmem[w_safeId] <= w_vstore;
            for (int j = 0; j < N_STAGE; j++) r_vlad[w_safeId][j] <= r_vladNew[j];
            if (w_refCur != '0)  r_refrac[w_safeId] <= w_refCur - RW'(1);
            else if (w_spike)    r_refrac[w_safeId] <= RW'(T_REF);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_lif_array.sv
// Directed bench for frac_lif_array: a table of hand-computed updates applied in order,
// followed by back-pressure and mid-update reset sequences.
module tb_frac_lif_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_id;
  logic [31:0] in_cur;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_id;
  logic [31:0] out_vmem;
  logic        out_spike;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] cur;
    logic [31:0] expVmem;
    logic        expSpike;
  } vec_t;

  vec_t vecs[12];

  frac_lif_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_id     (in_id),
    .in_cur    (in_cur),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_vmem  (out_vmem),
    .out_spike (out_spike)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // One request; returns the emitted fields and the accept-to-out_valid latency in cycles.
  task automatic applyStimulus(input logic [2:0] id, input logic [31:0] cur,
                               output logic [2:0] gotId, output logic [31:0] gotVmem,
                               output logic gotSpike, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_id    = id;
    in_cur   = cur;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    gotId    = out_id;
    gotVmem  = out_vmem;
    gotSpike = out_spike;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  gId;
    logic [31:0] gVm;
    logic        gSp;
    int          lat;
    int          seen;

    vecs[0]  = '{3'd1, 32'h0000_0000, 32'd0, 1'b0};
    vecs[1]  = '{3'd0, 32'h0005_0000, 32'd2, 1'b1};
    vecs[2]  = '{3'd0, 32'h0005_0000, 32'd1, 1'b0};
    vecs[3]  = '{3'd0, 32'h0005_0000, 32'd0, 1'b0};
    vecs[4]  = '{3'd1, 32'h0000_0000, 32'd0, 1'b0};
    vecs[5]  = '{3'd2, 32'h8000_0000, -32'sd214761472, 1'b0};
    vecs[6]  = '{3'd4, -32'sd327680, -32'sd32770, 1'b0};
    vecs[7]  = '{3'd4, 32'h0000_0000, -32'sd32238, 1'b0};
    vecs[8]  = '{3'd4, 32'h0000_0000, -32'sd31766, 1'b0};
    vecs[9]  = '{3'd4, 32'h0000_0000, -32'sd31339, 1'b0};
    vecs[10] = '{3'd5, 32'h7FFF_FFFF, 32'd214728703, 1'b1};
    vecs[11] = '{3'd0, 32'h0005_0000, 32'd2, 1'b1};

    in_valid  = 1'b0;
    in_id     = '0;
    in_cur    = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_vmem", out_vmem, 32'd0);
    checkOutput("reset out_spike", 32'(out_spike), 32'd0);
    checkOutput("reset out_id", 32'(out_id), 32'd0);
    #22;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].id, vecs[i].cur, gId, gVm, gSp, lat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("vec%0d out_id", i), 32'(gId), 32'(vecs[i].id));
      checkOutput($sformatf("vec%0d out_vmem", i), gVm, vecs[i].expVmem);
      checkOutput($sformatf("vec%0d out_spike", i), 32'(gSp), 32'(vecs[i].expSpike));
    end

    // Back-pressure: outputs must hold steady while out_ready is low.
    out_ready = 1'b0;
    applyStimulus(3'd6, 32'h0005_0000, gId, gVm, gSp, lat);
    checkOutput("stall latency", 32'(lat), 32'd4);
    checkOutput("stall out_vmem", gVm, 32'd2);
    checkOutput("stall out_spike", 32'(gSp), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall%0d out_id", c), 32'(out_id), 32'd6);
      checkOutput($sformatf("stall%0d out_vmem", c), out_vmem, 32'd2);
      checkOutput($sformatf("stall%0d out_spike", c), 32'(out_spike), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release out_valid", 32'(out_valid), 32'd0);
    checkOutput("release in_ready", 32'(in_ready), 32'd1);

    // Reset during ACC: the in-flight update vanishes and all neurons restart from zero.
    @(negedge clk);
    in_valid = 1'b1;
    in_id    = 3'd7;
    in_cur   = 32'h0005_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    checkOutput("midreset no emit", 32'(seen), 32'd0);
    applyStimulus(3'd7, 32'h0005_0000, gId, gVm, gSp, lat);
    checkOutput("post-reset id7 out_vmem", gVm, 32'd2);
    checkOutput("post-reset id7 out_spike", 32'(gSp), 32'd1);
    applyStimulus(3'd4, 32'h0000_0000, gId, gVm, gSp, lat);
    checkOutput("post-reset id4 out_vmem", gVm, 32'd0);
    checkOutput("post-reset id4 out_spike", 32'(gSp), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frac_lif_array.md
FRAC_LIF_ARRAY -- requirements
Module: frac_lif_array

Interface
REQ-001 SHALL have parameters (name, default, meaning): N_NEUR, 8, neuron count; N_STAGE, 3, ladder stages per neuron; W, 32, data width; F, 16, fractional bits; R_SHIFT, 4, ladder 1/R shift.
REQ-002 SHALL have parameters: K_TAU, 6554, dt/C0 (Q); K_LEAK, -6554, leak gain; A_LAD, 16384, ladder coupling; B_LAD, -16384, ladder self-term; V_TH, 32768, threshold; V_RESET, 32768, subtract-on-spike; T_REF, 2, refractory update count.
REQ-003 SHALL have ports: clk in 1 clock; rst_n in 1 reset (asynchronous, active-low).
REQ-004 SHALL have ports: in_valid in 1; in_ready out 1; in_id in clog2(N_NEUR) target neuron; in_cur in W signed input current (Q).
REQ-005 SHALL have ports: out_valid out 1; out_ready in 1; out_id out clog2(N_NEUR); out_vmem out W signed post-update membrane; out_spike out 1.

Function
REQ-006 SHALL store per neuron: vmem (W), vlad[0..N_STAGE-1] (W each), refrac counter (clog2(T_REF+1)).
REQ-007 SHALL use FSM IDLE -> ACC -> COMMIT -> EMIT -> IDLE; in_ready=1 only in IDLE; accept on in_valid&&in_ready.
REQ-008 ACC SHALL last exactly N_STAGE cycles, processing stage j in cycle j with one shared multiplier pair.
REQ-009 per stage j, prev_j = vmem (j=0) else old vlad[j-1]; Icap += (prev_j - vlad[j])>>>R_SHIFT; Ir += vlad[j]>>>R_SHIFT; vlad_next[j] = sat(vlad[j] + ((A_LAD*(prev_j-vlad[j]) + B_LAD*vlad[j])>>>F)); all terms use pre-update values.
REQ-010 COMMIT SHALL compute iin_eff = (refrac>0) ? 0 : in_cur; s = sat(iin_eff + ((K_LEAK*vmem)>>>F) - Icap + Ir); vnew = sat(vmem + ((K_TAU*s)>>>F)).
REQ-011 products SHALL be 2W-bit signed; >>> is arithmetic (floor); sat() clamps to [-2^(W-1), 2^(W-1)-1]; no wrap-around anywhere.
REQ-012 spike SHALL be 1 iff refrac==0 and vnew>=V_TH; then stored vmem=sat(vnew-V_RESET), refrac=T_REF; else stored vmem=vnew.
REQ-013 if refrac>0 at COMMIT, refrac SHALL decrement by 1 and spike=0.
REQ-014 COMMIT SHALL write vmem, vlad, refrac for in_id only; other neurons unchanged.
REQ-015 EMIT SHALL hold out_valid=1 with out_id, out_vmem (stored value), out_spike stable until out_ready=1; transfer completes on that edge.
REQ-016 out_valid SHALL rise N_STAGE+1 cycles after the accept edge; minimum spacing between accepts N_STAGE+3 cycles.
REQ-017 in_id >= N_NEUR SHALL be accepted and produce an EMIT with out_vmem=0, out_spike=0, no state write.

Reset
REQ-018 rst_n low SHALL asynchronously clear all vmem, vlad, refrac, FSM to IDLE, out_valid=0, out_spike=0, out_id=0, out_vmem=0; in_ready=1 after release.
REQ-019 reset mid-ACC/COMMIT/EMIT SHALL discard the in-flight update with no state write.

Structure
REQ-020 package frac_lif_pkg SHALL hold FSM state enum, sat() function, Q-format width localparams.
REQ-021 sub-module frac_lif_stage_alu SHALL implement REQ-009 combinationally for one stage; instantiated once, time-shared.

Verification
REQ-022 reset -> all outputs 0, in_ready=1; then id=1, in_cur=0 -> out_vmem=0, out_spike=0 at accept+4 cycles (defaults).
REQ-023 from reset, id=0, in_cur=0x0005_0000 -> out_vmem=2, out_spike=1; id=0 updates (in_cur=5.0) twice more -> out_vmem 1 then 0, out_spike=0 both (refractory).
REQ-024 after REQ-023, id=1 in_cur=0 -> out_vmem=0, out_spike=0 (isolation).
REQ-025 from reset, id=2, in_cur=0x8000_0000 -> out_vmem=-214761472, out_spike=0 (saturated s).
REQ-026 out_ready=0 for 5 cycles in EMIT -> out fields stable, in_ready=0, single transfer when released.
REQ-027 rst_n pulsed during ACC -> out_valid never asserts, next update of that id starts from vmem=0.
